// File: rtl/regfile_sb_pkg.sv
// Shared types and defaults for the integer register file and its write-back path.
package rv_pkg;

    // Write-back formatting modes; codes 5-7 are treated as WB_WORD.
    typedef enum logic [2:0] {
        WB_WORD = 3'd0,
        WB_LB   = 3'd1,
        WB_LH   = 3'd2,
        WB_LBU  = 3'd3,
        WB_LHU  = 3'd4
    } wb_mode_e;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode / write-back bus into the register file.
// The master drives reads, issue and write-back; the slave is the register file.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
);
    // Read ports: port k owns element [k], equal to bits [k*AW +: AW] flattened.
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;

    // Write-back
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [XLEN-1:0]          wr_data;
    logic [2:0]               wr_mode;

    // Load issue / scoreboard
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     flush;
    logic                     busy_any;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_mode, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, busy_any
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_mode, iss_en, iss_addr, flush,
        output rd_data, rd_busy, busy_any
    );
endinterface

// File: rtl/regfile_sb_load_extend.sv
// Combinational load formatter: sign/zero extends byte and halfword loads to XLEN.
// Kept standalone so other write-back paths can reuse it.
module load_extend
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] wr_data,
    input  logic [2:0]      wr_mode,
    output logic [XLEN-1:0] wdata_f
);

    // Select the extension for the current mode; unknown codes pass the word through.
    always_comb begin
        wdata_f = wr_data;
        case (wr_mode)
            WB_LB:   wdata_f = {{(XLEN-8){wr_data[7]}},   wr_data[7:0]};
            WB_LH:   wdata_f = {{(XLEN-16){wr_data[15]}}, wr_data[15:0]};
            WB_LBU:  wdata_f = {{(XLEN-8){1'b0}},         wr_data[7:0]};
            WB_LHU:  wdata_f = {{(XLEN-16){1'b0}},        wr_data[15:0]};
            default: wdata_f = wr_data;
        endcase
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with multi-port combinational reads, one formatted
// write port with same-cycle bypass, and a per-register load busy scoreboard.
module regfile_sb
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    logic [NREG-1:0][XLEN-1:0] mem;
    logic [NREG-1:0]           busy;
    logic [XLEN-1:0]           wdata_f;
    logic                      wr_ok;
    logic [NRD-1:0][XLEN-1:0]  rdata;
    logic [NRD-1:0]            rbusy;

    load_extend #(.XLEN(XLEN)) u_ext (
        .wr_data (bus.wr_data),
        .wr_mode (bus.wr_mode),
        .wdata_f (wdata_f)
    );

    // x0 is never written; out-of-range destinations (non-power-of-two NREG) are dropped.
    assign wr_ok = bus.wr_en && (bus.wr_addr != '0) &&
                   ({1'b0, bus.wr_addr} < (AW+1)'(NREG));

    // Register storage: single write port, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= wdata_f;
        end
    end

    // Scoreboard: flush beats issue, issue beats the write-back clear; x0 never busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int r = 1; r < NREG; r++) begin
                if (bus.flush)
                    busy[r] <= 1'b0;
                else if (bus.iss_en && bus.iss_addr == AW'(r))
                    busy[r] <= 1'b1;
                else if (bus.wr_en && bus.wr_addr == AW'(r))
                    busy[r] <= 1'b0;
            end
        end
    end

    // Read ports: zero for x0/out-of-range/reset, bypass on a matching write,
    // and hide busy when that write is delivering the data this cycle.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rst && bus.rd_addr[k] != '0 &&
                {1'b0, bus.rd_addr[k]} < (AW+1)'(NREG)) begin
                if (bus.wr_en && bus.wr_addr == bus.rd_addr[k]) begin
                    rdata[k] = wdata_f;
                    rbusy[k] = 1'b0;
                end else begin
                    rdata[k] = mem[bus.rd_addr[k]];
                    rbusy[k] = busy[bus.rd_addr[k]];
                end
            end
        end
    end

    assign bus.rd_data  = rdata;
    assign bus.rd_busy  = rbusy;
    assign bus.busy_any = |busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb.
module tb_regfile_sb;
    import rv_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 2 time units after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.iss_en   = 1'b0;
        bus.flush    = 1'b0;
    endtask

    logic [31:0] fmt_exp [5];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_mode  = 3'd0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.flush    = 1'b0;
        fmt_exp[0] = 32'h1234_8086;
        fmt_exp[1] = 32'hFFFF_FF86;
        fmt_exp[2] = 32'hFFFF_8086;
        fmt_exp[3] = 32'h0000_0086;
        fmt_exp[4] = 32'h0000_8086;

        // Reset state
        #2;
        bus.rd_addr[0] = 5'd7;
        #1;
        chk("rst_rd_data", bus.rd_data[0], 0);
        chk("rst_busy_any", bus.busy_any, 0);
        #9 rst = 1'b1;   // released at t=12, between edges

        // All registers read zero after reset on both ports
        for (int i = 0; i < NREG; i++) begin
            bus.rd_addr[0] = 5'(i);
            bus.rd_addr[1] = 5'(NREG-1-i);
            #1;
            chk("init_rd0", bus.rd_data[0], 0);
            chk("init_rd1", bus.rd_data[1], 0);
            chk("init_busy", bus.rd_busy, 0);
        end
        chk("init_busy_any", bus.busy_any, 0);

        // Write to x0 is ignored, including the bypass
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hDEAD_BEEF;
        bus.wr_mode = 3'd0; bus.rd_addr[0] = 5'd0;
        #1;
        chk("x0_bypass", bus.rd_data[0], 0);
        tick();
        idle();
        #1;
        chk("x0_after", bus.rd_data[0], 0);

        // Formatter, one write per mode to x5
        for (int m = 0; m < 5; m++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'h1234_8086;
            bus.wr_mode = 3'(m);
            tick();
            idle();
            bus.rd_addr[0] = 5'd5;
            #1;
            chk($sformatf("fmt_mode%0d", m), bus.rd_data[0], fmt_exp[m]);
        end

        // Reserved mode code 7 behaves as WORD
        bus.wr_en = 1'b1; bus.wr_addr = 5'd6; bus.wr_data = 32'hCAFE_F00D;
        bus.wr_mode = 3'd7;
        tick();
        idle();
        bus.rd_addr[1] = 5'd6;
        #1;
        chk("fmt_mode7", bus.rd_data[1], 32'hCAFE_F00D);

        // Same-cycle bypass, then the stored value
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h55;
        bus.wr_mode = 3'd0; bus.rd_addr[0] = 5'd7;
        #1;
        chk("bypass_same", bus.rd_data[0], 32'h55);
        tick();
        idle();
        #1;
        chk("bypass_next", bus.rd_data[0], 32'h55);

        // Scoreboard: issue to x9, then write-back clears it
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9; bus.rd_addr[1] = 5'd9;
        #1;
        chk("sb_pre_busy", bus.rd_busy[1], 0);
        tick();
        idle();
        #1;
        chk("sb_busy", bus.rd_busy[1], 1);
        chk("sb_busy_any", bus.busy_any, 1);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h99;
        bus.wr_mode = 3'd0;
        #1;
        chk("sb_wb_busy", bus.rd_busy[1], 0);
        chk("sb_wb_data", bus.rd_data[1], 32'h99);
        chk("sb_wb_any", bus.busy_any, 1);
        tick();
        idle();
        #1;
        chk("sb_clr_busy", bus.rd_busy[1], 0);
        chk("sb_clr_any", bus.busy_any, 0);

        // Issue and write the same register: written and still busy
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h33; bus.wr_mode = 3'd0;
        tick();
        idle();
        bus.rd_addr[0] = 5'd3;
        #1;
        chk("set_win_data", bus.rd_data[0], 32'h33);
        chk("set_win_busy", bus.rd_busy[0], 1);
        chk("set_win_any", bus.busy_any, 1);

        // Re-issue to a busy register stays busy
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        tick();
        idle();
        #1;
        chk("reissue_busy", bus.rd_busy[0], 1);

        // Flush with a same-cycle issue on x4: nothing busy, x3 cleared too
        bus.iss_en = 1'b1; bus.iss_addr = 5'd4; bus.flush = 1'b1;
        tick();
        idle();
        bus.rd_addr[1] = 5'd4;
        #1;
        chk("flush_any", bus.busy_any, 0);
        chk("flush_x4", bus.rd_busy[1], 0);
        chk("flush_x3", bus.rd_busy[0], 0);

        // Issue to x0 never marks anything busy
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        tick();
        idle();
        bus.rd_addr[0] = 5'd0;
        #1;
        chk("iss_x0_any", bus.busy_any, 0);
        chk("iss_x0_busy", bus.rd_busy[0], 0);

        // Async reset mid-run
        bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'hAA; bus.wr_mode = 3'd0;
        tick();
        idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd11;
        tick();
        idle();
        bus.rd_addr[0] = 5'd10; bus.rd_addr[1] = 5'd11;
        #1;
        chk("pre_rst_data", bus.rd_data[0], 32'hAA);
        chk("pre_rst_busy", bus.rd_busy[1], 1);
        chk("pre_rst_any", bus.busy_any, 1);
        #1 rst = 1'b0;   // well before the next rising edge
        #1;
        chk("arst_data", bus.rd_data[0], 0);
        chk("arst_busy", bus.rd_busy[1], 0);
        chk("arst_any", bus.busy_any, 0);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'h77;
        #1;
        chk("arst_bypass", bus.rd_data[0], 0);
        tick();
        idle();
        rst = 1'b1;
        #1;
        chk("post_rst_x10", bus.rd_data[0], 0);
        chk("post_rst_any", bus.busy_any, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
